// File: rtl/queue_arbiter_ctrl_pkg.sv
// Shared constants and read-side state encoding for queue_arbiter_ctrl.
// Queue geometry is fixed by the attached 8-entry, 8-bit queue.
package queue_arb_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_CAPT,
        S_PRESENT
    } rd_state_t;
endpackage

// File: rtl/queue_arbiter_ctrl_if.sv
// Producer, queue and consumer signals of queue_arbiter_ctrl.
// slave is the controller side, master is the surrounding system.
interface queue_arbiter_ctrl_if
    import queue_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]             req_in;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data_in;
    logic [NUM_REQ-1:0]             grant_out;
    logic [DATA_W-1:0]              q_data_out;
    logic                           q_enqueue_out;
    logic                           q_dequeue_out;
    logic [DATA_W-1:0]              q_data_in;
    logic [LEN_W-1:0]               q_len_in;
    logic [LEN_W-1:0]               occ_out;
    logic                           cons_valid_out;
    logic [DATA_W-1:0]              cons_data_out;
    logic                           cons_ack_in;

    modport slave (
        input  req_in, req_data_in, q_data_in, q_len_in, cons_ack_in,
        output grant_out, q_data_out, q_enqueue_out, q_dequeue_out,
        output occ_out, cons_valid_out, cons_data_out
    );

    modport master (
        output req_in, req_data_in, q_data_in, q_len_in, cons_ack_in,
        input  grant_out, q_data_out, q_enqueue_out, q_dequeue_out,
        input  occ_out, cons_valid_out, cons_data_out
    );
endinterface

// File: rtl/queue_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_i,
// wrapping around; returns one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);
    int unsigned      pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos  = (int'(last_i) + i) % NUM_REQ;
            cand = IDX_W'(pos);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/queue_arbiter_ctrl.sv
// Round-robin write arbiter and valid/ack read sequencer for an 8x8 queue.
// Optional QARB_STALL_CNT_EN adds stall_cnt_out and a queue-length check.
module queue_arbiter_ctrl
    import queue_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk_10khz,
    input  logic                 reset,
    queue_arbiter_ctrl_if.slave  bus
`ifdef QARB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt_out
`endif
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rd_state_t          state_q;
    logic [LEN_W-1:0]   occ_q, occ_d;
    logic [IDX_W-1:0]   rr_last_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [DATA_W-1:0]  q_data_q;
    logic               enq_q;
    logic               deq_q;
    logic               valid_q;
    logic [DATA_W-1:0]  cons_data_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               can_grant;
    logic               pop_go;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i  (bus.req_in),
        .last_i (rr_last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // occ already counts words granted this edge, so a full queue blocks at once
    assign can_grant = pick_vld && (occ_q < LEN_W'(DEPTH));
    assign pop_go    = (occ_q != '0) &&
                       ((state_q == S_IDLE) ||
                        ((state_q == S_PRESENT) && bus.cons_ack_in));
    assign occ_d     = occ_q + LEN_W'(can_grant) - LEN_W'(pop_go);

    always_ff @(posedge clk_10khz or posedge reset) begin
        if (reset) begin
            grant_q   <= '0;
            enq_q     <= 1'b0;
            q_data_q  <= '0;
            rr_last_q <= IDX_W'(NUM_REQ - 1);
            occ_q     <= '0;
        end else begin
            grant_q <= can_grant ? pick_gnt : '0;
            enq_q   <= can_grant;
            occ_q   <= occ_d;
            if (can_grant) begin
                q_data_q  <= bus.req_data_in[pick_idx];
                rr_last_q <= pick_idx;
            end
        end
    end

    always_ff @(posedge clk_10khz or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            deq_q       <= 1'b0;
            valid_q     <= 1'b0;
            cons_data_q <= '0;
        end else begin
            deq_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop_go) begin
                        state_q <= S_POP;
                        deq_q   <= 1'b1;
                    end
                end
                S_POP: state_q <= S_CAPT;
                S_CAPT: begin
                    cons_data_q <= bus.q_data_in;
                    valid_q     <= 1'b1;
                    state_q     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.cons_ack_in) begin
                        valid_q <= 1'b0;
                        if (pop_go) begin
                            state_q <= S_POP;
                            deq_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant_out      = grant_q;
    assign bus.q_data_out     = q_data_q;
    assign bus.q_enqueue_out  = enq_q;
    assign bus.q_dequeue_out  = deq_q;
    assign bus.occ_out        = occ_q;
    assign bus.cons_valid_out = valid_q;
    assign bus.cons_data_out  = cons_data_q;

`ifdef QARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_10khz or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((|bus.req_in) && (occ_q == LEN_W'(DEPTH)) &&
                     (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_out = stall_q;

    // queue length lags occ by one edge
    a_len_tracks_occ: assert property (
        @(posedge clk_10khz) disable iff (reset)
        (enq_q || deq_q) |=> (bus.q_len_in == $past(occ_q))
    );
`else
    logic len_unused;
    assign len_unused = ^bus.q_len_in;
`endif
endmodule

// File: tb/tb_queue_arbiter_ctrl.sv
// Bench for queue_arbiter_ctrl: queue model, table vectors, corner
// sequences and random traffic against a transaction-level reference.
module tb_queue_arbiter_ctrl;
    import queue_arb_pkg::*;

    localparam int NR      = 4;
    localparam int RD_IDLE = 0;
    localparam int RD_POP  = 1;
    localparam int RD_CAPT = 2;
    localparam int RD_PRES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_arbiter_ctrl_if #(.NUM_REQ(NR)) bus();
`ifdef QARB_STALL_CNT_EN
    logic [15:0] stall;
`endif

    queue_arbiter_ctrl #(.NUM_REQ(NR)) dut (
        .clk_10khz (clk),
        .reset     (rst),
        .bus       (bus)
`ifdef QARB_STALL_CNT_EN
        ,
        .stall_cnt_out (stall)
`endif
    );

    // queue: registered read on dequeue, length updated each edge
    logic [7:0] qmem[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qmem.delete();
            bus.q_data_in <= '0;
            bus.q_len_in  <= '0;
        end else begin
            if (bus.q_dequeue_out && qmem.size() > 0)
                bus.q_data_in <= qmem.pop_front();
            if (bus.q_enqueue_out && qmem.size() < DEPTH)
                qmem.push_back(bus.q_data_out);
            bus.q_len_in <= LEN_W'(qmem.size());
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference: words accepted but not yet popped live in m_fifo
    int         m_occ, m_last, m_rd, m_stall;
    logic [7:0] m_fifo[$];
    logic [7:0] m_cur;
    logic [3:0] e_grant;
    logic       e_enq, e_deq, e_valid;
    logic [7:0] e_qdata, e_cdata;

    task automatic model_reset();
        m_occ = 0; m_last = NR - 1; m_rd = RD_IDLE; m_stall = 0;
        m_fifo.delete(); m_cur = '0;
        e_grant = '0; e_enq = 0; e_deq = 0; e_valid = 0;
        e_qdata = '0; e_cdata = '0;
    endtask

    task automatic model_step(input logic [NR-1:0] r,
                              input logic [NR-1:0][7:0] d, input logic a);
        int pick;
        bit pop;
        pick = -1;
        if (r != 0 && m_occ == DEPTH && m_stall < 65535) m_stall++;
        if (m_occ < DEPTH)
            for (int i = 1; i <= NR; i++) begin
                int j;
                j = (m_last + i) % NR;
                if (pick < 0 && r[j]) pick = j;
            end
        pop = (m_occ > 0) && (m_rd == RD_IDLE || (m_rd == RD_PRES && a));
        e_grant = '0; e_enq = 0; e_deq = pop;
        if (pick >= 0) begin
            e_grant[pick] = 1'b1; e_enq = 1'b1;
            e_qdata = d[pick]; m_last = pick;
            m_fifo.push_back(d[pick]);
        end
        if (m_rd == RD_PRES && a) e_valid = 1'b0;
        if (pop) begin
            m_rd = RD_POP; m_cur = m_fifo.pop_front();
        end else if (m_rd == RD_POP) begin
            m_rd = RD_CAPT;
        end else if (m_rd == RD_CAPT) begin
            m_rd = RD_PRES; e_valid = 1'b1; e_cdata = m_cur;
        end else if (m_rd == RD_PRES && a) begin
            m_rd = RD_IDLE;
        end
        m_occ = m_occ + (pick >= 0 ? 1 : 0) - (pop ? 1 : 0);
    endtask

    task automatic compare_all();
        check("grant", 32'(bus.grant_out), 32'(e_grant));
        check("enqueue", 32'(bus.q_enqueue_out), 32'(e_enq));
        check("dequeue", 32'(bus.q_dequeue_out), 32'(e_deq));
        check("q_data", 32'(bus.q_data_out), 32'(e_qdata));
        check("occ", 32'(bus.occ_out), 32'(m_occ));
        check("cons_valid", 32'(bus.cons_valid_out), 32'(e_valid));
        check("cons_data", 32'(bus.cons_data_out), 32'(e_cdata));
`ifdef QARB_STALL_CNT_EN
        check("stall_cnt", 32'(stall), 32'(m_stall));
`endif
    endtask

    task automatic tick();
        logic [NR-1:0]      r;
        logic [NR-1:0][7:0] d;
        logic               a;
        r = bus.req_in; d = bus.req_data_in; a = bus.cons_ack_in;
        @(posedge clk);
        model_step(r, d, a);
        #1;
        compare_all();
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic set_data_10();
        for (int k = 0; k < NR; k++) bus.req_data_in[k] = 8'(8'h10 + k);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] occ;
        logic       deq;
        logic       valid;
        logic [7:0] qdata;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'hF, 4'b0001, 4'd1, 1'b0, 1'b0, 8'h10};
        tbl[1]  = '{4'hF, 4'b0010, 4'd1, 1'b1, 1'b0, 8'h11};
        tbl[2]  = '{4'hF, 4'b0100, 4'd2, 1'b0, 1'b0, 8'h12};
        tbl[3]  = '{4'hF, 4'b1000, 4'd3, 1'b0, 1'b1, 8'h13};
        tbl[4]  = '{4'hF, 4'b0001, 4'd4, 1'b0, 1'b1, 8'h10};
        tbl[5]  = '{4'hF, 4'b0010, 4'd5, 1'b0, 1'b1, 8'h11};
        tbl[6]  = '{4'hF, 4'b0100, 4'd6, 1'b0, 1'b1, 8'h12};
        tbl[7]  = '{4'hF, 4'b1000, 4'd7, 1'b0, 1'b1, 8'h13};
        tbl[8]  = '{4'hF, 4'b0001, 4'd8, 1'b0, 1'b1, 8'h10};
        tbl[9]  = '{4'hF, 4'b0000, 4'd8, 1'b0, 1'b1, 8'h10};
        tbl[10] = '{4'hF, 4'b0000, 4'd8, 1'b0, 1'b1, 8'h10};
        tbl[11] = '{4'hF, 4'b0000, 4'd8, 1'b0, 1'b1, 8'h10};

        bus.req_in = '0; bus.req_data_in = '0; bus.cons_ack_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // single word, ack tied high
        bus.req_in = 4'b0001; bus.req_data_in[0] = 8'hA5;
        bus.cons_ack_in = 1'b1;
        tick();
        check("t1_grant", 32'(bus.grant_out), 32'h1);
        check("t1_enq", 32'(bus.q_enqueue_out), 32'h1);
        check("t1_qdata", 32'(bus.q_data_out), 32'hA5);
        check("t1_occ", 32'(bus.occ_out), 32'h1);
        bus.req_in = '0;
        tick();
        check("t1_deq", 32'(bus.q_dequeue_out), 32'h1);
        check("t1_occ0", 32'(bus.occ_out), 32'h0);
        tick();
        tick();
        check("t1_valid", 32'(bus.cons_valid_out), 32'h1);
        check("t1_cdata", 32'(bus.cons_data_out), 32'hA5);
        tick();
        check("t1_valid_drop", 32'(bus.cons_valid_out), 32'h0);

        // four producers, consumer stalled, fill to full
        hard_reset();
        set_data_10();
        bus.cons_ack_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.req_in = tbl[i].req;
            tick();
            check("tbl_grant", 32'(bus.grant_out), 32'(tbl[i].grant));
            check("tbl_occ", 32'(bus.occ_out), 32'(tbl[i].occ));
            check("tbl_deq", 32'(bus.q_dequeue_out), 32'(tbl[i].deq));
            check("tbl_valid", 32'(bus.cons_valid_out), 32'(tbl[i].valid));
            check("tbl_qdata", 32'(bus.q_data_out), 32'(tbl[i].qdata));
        end

        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_cdata", 32'(bus.cons_data_out), 32'h10);
            check("hold_deq", 32'(bus.q_dequeue_out), 32'h0);
            check("hold_valid", 32'(bus.cons_valid_out), 32'h1);
        end

        // one ack frees exactly one slot
        bus.cons_ack_in = 1'b1;
        tick();
        check("full_deq", 32'(bus.q_dequeue_out), 32'h1);
        check("full_occ7", 32'(bus.occ_out), 32'h7);
        check("full_nogrant", 32'(bus.grant_out), 32'h0);
        bus.cons_ack_in = 1'b0;
        tick();
        check("refill_grant", 32'(bus.grant_out), 32'b0010);
        check("refill_occ", 32'(bus.occ_out), 32'h8);
        check("refill_qdata", 32'(bus.q_data_out), 32'h11);
        tick();
        check("refill_stop", 32'(bus.grant_out), 32'h0);
        check("next_cdata", 32'(bus.cons_data_out), 32'h11);

        // enqueue and dequeue on the same edge at occ 7
        bus.req_in = '0; bus.cons_ack_in = 1'b1;
        tick();
        tick();
        tick();
        bus.req_in = 4'b0001; bus.req_data_in[0] = 8'h55;
        tick();
        check("simul_enq", 32'(bus.q_enqueue_out), 32'h1);
        check("simul_deq", 32'(bus.q_dequeue_out), 32'h1);
        check("simul_occ", 32'(bus.occ_out), 32'h7);
        check("simul_grant", 32'(bus.grant_out), 32'b0001);
        bus.req_in = '0;
        repeat (40) tick();
        check("drain_occ", 32'(bus.occ_out), 32'h0);
        check("drain_valid", 32'(bus.cons_valid_out), 32'h0);

        // asynchronous reset while presenting with occ 5
        hard_reset();
        set_data_10();
        bus.req_in = 4'hF; bus.cons_ack_in = 1'b0;
        repeat (6) tick();
        bus.req_in = '0;
        check("pre_rst_occ", 32'(bus.occ_out), 32'h5);
        check("pre_rst_valid", 32'(bus.cons_valid_out), 32'h1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_grant", 32'(bus.grant_out), 32'h0);
        check("rst_enq", 32'(bus.q_enqueue_out), 32'h0);
        check("rst_deq", 32'(bus.q_dequeue_out), 32'h0);
        check("rst_qdata", 32'(bus.q_data_out), 32'h0);
        check("rst_occ", 32'(bus.occ_out), 32'h0);
        check("rst_valid", 32'(bus.cons_valid_out), 32'h0);
        check("rst_cdata", 32'(bus.cons_data_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_in = 4'hF;
        tick();
        check("post_rst_grant", 32'(bus.grant_out), 32'b0001);
        bus.req_in = '0;

        // random traffic with phases of fast, slow and medium consumer
        hard_reset();
        for (int c = 0; c < 1500; c++) begin
            int pct;
            pct = ((c / 150) % 3 == 0) ? 85 : (((c / 150) % 3 == 1) ? 8 : 45);
            for (int k = 0; k < NR; k++) begin
                if (e_grant[k]) begin
                    if ($urandom_range(0, 1) == 0) bus.req_in[k] = 1'b0;
                    else bus.req_data_in[k] = 8'($urandom);
                end else if (!bus.req_in[k] && $urandom_range(0, 2) == 0) begin
                    bus.req_in[k] = 1'b1;
                    bus.req_data_in[k] = 8'($urandom);
                end
            end
            bus.cons_ack_in = (int'($urandom_range(0, 99)) < pct);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
